mmio_uart_console: RTL and testbench



---
 rtl/mmio_uart_console.sv | 206 ++++++++++++++++++++
 tb/tb_mmio_uart_console.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_console.sv
// rtl/mmio_uart_console.sv - MMIO halt register + FIFO-buffered 8N1 UART TX console; optional MMIO_UART_CYCLE_COUNTER_EN cycle counter
module mmio_uart_console #(
    parameter logic [31:0] BASE            = 32'hf0000000,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] DIV_DEFAULT     = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        oe,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        txd,
    output logic        halt,
    output logic [31:0] halt_code
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE    = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

    localparam logic [9:0] W_HALT   = 10'h000;
    localparam logic [9:0] W_TXDATA = 10'h040;
    localparam logic [9:0] W_STATUS = 10'h041;
    localparam logic [9:0] W_DIV    = 10'h042;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic       sel, is_wr, rd_en;
    logic [9:0] word;
    logic       wr_halt, wr_tx, wr_status, wr_div;
    logic       unused_addr;

    assign sel         = oe && (addr[31:12] == BASE[31:12]);
    assign is_wr       = |we;
    assign word        = addr[11:2];
    assign rd_en       = sel && !is_wr;
    assign wr_halt     = sel && is_wr && (word == W_HALT);
    assign wr_tx       = sel && is_wr && (word == W_TXDATA) && we[0];
    assign wr_status   = sel && is_wr && (word == W_STATUS);
    assign wr_div      = sel && is_wr && (word == W_DIV) && (we[1:0] != 2'b00);
    assign unused_addr = ^addr[1:0];

    logic [7:0]                 fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       full, empty, push, pop, overflow;
    logic [15:0]                divisor;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push  = wr_tx && (!full || pop);

    tx_state_t   state, state_next;
    logic [15:0] baud_cnt, baud_next, div_latched, div_lat_next;
    logic [2:0]  bit_idx, bit_next;
    logic [7:0]  shift, shift_next;
    logic        txd_next, bit_done, idle;

    assign bit_done = (baud_cnt == div_latched - 16'd1);
    assign idle     = empty && (state == S_IDLE);

    always_comb begin
        state_next   = state;
        baud_next    = baud_cnt;
        bit_next     = bit_idx;
        shift_next   = shift;
        div_lat_next = div_latched;
        pop          = 1'b0;
        txd_next     = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_mem[rd_ptr];
                    div_lat_next = (divisor == 16'd0) ? 16'd1 : divisor;
                    baud_next    = 16'd0;
                    bit_next     = 3'd0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_next  = 16'd0;
                    state_next = S_DATA;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_next  = 16'd0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_next = S_STOP;
                    else                 bit_next   = bit_idx + 3'd1;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_done) state_next = S_IDLE;
                else          baud_next  = baud_cnt + 16'd1;
            end
            default: state_next = S_IDLE;
        endcase
        // txd is registered from the next state so the line never glitches on state decode.
        case (state_next)
            S_START: txd_next = 1'b0;
            S_DATA:  txd_next = shift_next[0];
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            baud_cnt    <= 16'd0;
            bit_idx     <= 3'd0;
            shift       <= 8'd0;
            div_latched <= 16'd1;
            txd         <= 1'b1;
        end else begin
            state       <= state_next;
            baud_cnt    <= baud_next;
            bit_idx     <= bit_next;
            shift       <= shift_next;
            div_latched <= div_lat_next;
            txd         <= txd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wdata[7:0];
    end

`ifdef MMIO_UART_CYCLE_COUNTER_EN
    localparam logic [9:0] W_CNT_LO = 10'h080;
    localparam logic [9:0] W_CNT_HI = 10'h081;

    logic [63:0] cyc_cnt;
    logic [31:0] cnt_shadow;

    // Reading the low word freezes the high word so a low-then-high pair is coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt    <= 64'd0;
            cnt_shadow <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
            if (rd_en && (word == W_CNT_LO)) cnt_shadow <= cyc_cnt[63:32];
        end
    end
`endif

    logic [31:0] rd_val;
    logic [7:0]  occ;
    assign occ = 8'(count);

    always_comb begin
        rd_val = 32'd0;
        case (word)
            W_HALT:   rd_val = halt_code;
            W_TXDATA: rd_val = {31'd0, !full};
            W_STATUS: rd_val = {16'd0, occ, 5'd0, overflow, idle, !full};
            W_DIV:    rd_val = {16'd0, divisor};
`ifdef MMIO_UART_CYCLE_COUNTER_EN
            W_CNT_LO: rd_val = cyc_cnt[31:0];
            W_CNT_HI: rd_val = cnt_shadow;
`endif
            default:  rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            halt      <= 1'b0;
            halt_code <= 32'd0;
            divisor   <= DIV_DEFAULT;
            ready     <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
            if (wr_tx && full && !pop)       overflow <= 1'b1;
            else if (wr_status && wdata[2])  overflow <= 1'b0;
            if (wr_halt && !halt) begin
                halt      <= 1'b1;
                halt_code <= wdata;
            end
            if (wr_div) divisor <= wdata[15:0];
            ready <= sel;
            rdata <= rd_en ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_console.sv
// tb/tb_mmio_uart_console.sv - scoreboard bench for mmio_uart_console (bus reads and UART bytes)
module tb_mmio_uart_console;

    localparam logic [31:0] BASE  = 32'hf0000000;
    localparam int          LOG2  = 4;
    localparam int          DEPTH = 1 << LOG2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        oe = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  we = 4'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        txd;
    logic        halt;
    logic [31:0] halt_code;

    mmio_uart_console #(
        .BASE(BASE), .FIFO_DEPTH_LOG2(LOG2), .DIV_DEFAULT(16'd868)
    ) dut (
        .clk(clk), .rst(rst), .oe(oe), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .ready(ready), .txd(txd), .halt(halt), .halt_code(halt_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [32:0] rd_q[$];
    string       rd_tag_q[$];
    logic [7:0]  tx_q[$];
    int          cur_div = 868;
    bit          mon_en = 1'b1;

    logic        exp_rdy;
    logic [63:0] cyc_model;
    logic [32:0] sb_e;
    string       sb_t;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_rdy   <= 1'b0;
            cyc_model <= 64'd0;
        end else begin
            exp_rdy   <= oe && (addr[31:12] == BASE[31:12]);
            cyc_model <= cyc_model + 64'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ready || exp_rdy) check_eq("ready", 64'(ready), 64'(exp_rdy));
            if (ready) begin
                check_eq("rd_q_nonempty", 64'(rd_q.size() != 0), 64'(1));
                if (rd_q.size() != 0) begin
                    sb_e = rd_q.pop_front();
                    sb_t = rd_tag_q.pop_front();
                    if (sb_e[32]) check_eq(sb_t, 64'(rdata), 64'(sb_e[31:0]));
                end
            end
        end
    end

    initial begin : uart_mon
        int d, pos, target;
        logic [7:0] b;
        logic stopb;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                d = cur_div;
                pos = 0;
                b = 8'd0;
                for (int k = 0; k < 8; k++) begin
                    target = d * (k + 1) + d / 2;
                    while (pos < target) begin @(negedge clk); pos++; end
                    b[k] = txd;
                end
                target = d * 9 + d / 2;
                while (pos < target) begin @(negedge clk); pos++; end
                stopb = txd;
                if (mon_en) begin
                    check_eq("stop_bit", 64'(stopb), 64'(1));
                    check_eq("tx_q_nonempty", 64'(tx_q.size() != 0), 64'(1));
                    if (tx_q.size() != 0) check_eq("tx_byte", 64'(b), 64'(tx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                             input logic [31:0] exp, input string tag);
        oe = 1'b1; addr = a; wdata = d; we = w;
        if (a[31:12] == BASE[31:12]) begin
            rd_q.push_back({(w == 4'd0), exp});
            rd_tag_q.push_back(tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        oe = 1'b0; addr = 32'd0; wdata = 32'd0; we = 4'd0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] w);
        bus_cycle(BASE + off, d, w, 32'd0, "wr");
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
        bus_cycle(BASE + off, 32'd0, 4'd0, exp, tag);
        bus_idle();
    endtask

    task automatic tx_push(input logic [7:0] b, input bit accepted);
        if (accepted) tx_q.push_back(b);
        bus_cycle(BASE + 32'h100, {24'd0, b}, 4'b0001, 32'd0, "tx_wr");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < 20000) begin @(posedge clk); n++; end
        check_eq("tx_drain", 64'(tx_q.size()), 64'(0));
        repeat (2 * cur_div + 4) @(posedge clk);
        #1;
    endtask

    int          n, seg;
    logic [63:0] cap, ew;
    logic [7:0]  wb;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_txd", 64'(txd), 64'(1));
        check_eq("rst_halt", 64'(halt), 64'(0));
        check_eq("rst_halt_code", 64'(halt_code), 64'(0));
        check_eq("rst_ready", 64'(ready), 64'(0));
        check_eq("rst_rdata", 64'(rdata), 64'(0));
        rd(32'h104, 32'h3, "status_reset");
        rd(32'h108, 32'd868, "div_reset");
        rd(32'h105, 32'h3, "status_misaligned");
        rd(32'h00c, 32'h0, "unmapped_rd");
        wr(32'h00c, 32'hffffffff, 4'hf);
        rd(32'h10c, 32'h0, "unmapped_rd2");

        bus_cycle(32'he0000104, 32'd0, 4'd0, 32'd0, "unsel");
        bus_idle();
        check_eq("ready_unselected", 64'(ready), 64'(0));

        wr(32'h108, 32'h00000077, 4'b1100);
        rd(32'h108, 32'd868, "div_upper_we_ignored");
        wr(32'h108, 32'd4, 4'b0011);
        cur_div = 4;
        rd(32'h108, 32'd4, "div_rd");

        wb = 8'h41;
        tx_push(wb, 1'b1);
        bus_idle();
        n = 0;
        do begin @(negedge clk); n++; end while (txd !== 1'b0 && n < 20);
        check_eq("tx_start_latency", 64'(n), 64'(2));
        cap = 64'd0;
        cap[0] = txd;
        for (int i = 1; i < 41; i++) begin @(negedge clk); cap[i] = txd; end
        ew = 64'd0;
        for (int i = 0; i < 41; i++) begin
            seg = i / 4;
            if (seg == 0)      ew[i] = 1'b0;
            else if (seg <= 8) ew[i] = wb[seg-1];
            else               ew[i] = 1'b1;
        end
        check_eq("tx_wave_0x41", cap, ew);
        sync();
        drain();
        rd(32'h104, 32'h3, "status_idle_after_frame");

        wr(32'h108, 32'd0, 4'b0001);
        rd(32'h108, 32'd0, "div_zero_rd");
        cur_div = 1;
        tx_push(8'ha5, 1'b1);
        tx_push(8'h3c, 1'b1);
        bus_idle();
        drain();
        rd(32'h104, 32'h3, "status_idle_div0");

        wr(32'h108, 32'd20, 4'b0011);
        cur_div = 20;
        for (int i = 0; i < DEPTH + 2; i++) tx_push(8'(8'h80 + i), i <= DEPTH);
        bus_idle();
        rd(32'h104, 32'((DEPTH << 8) | 4), "status_overflow");
        rd(32'h100, 32'h0, "txdata_full");
        wr(32'h104, 32'h3, 4'hf);
        rd(32'h104, 32'((DEPTH << 8) | 4), "status_w1c_bit2_clear_only");
        wr(32'h104, 32'h4, 4'hf);
        rd(32'h104, 32'(DEPTH << 8), "status_ovf_cleared");
        wr(32'h108, 32'd1, 4'b0011);
        cur_div = 1;
        repeat (230) @(posedge clk);
        #1;
        rd(32'h100, 32'h1, "txdata_after_pop");
        drain();
        rd(32'h104, 32'h3, "status_idle_after_burst");

        wr(32'h000, 32'hdead0001, 4'hf);
        wr(32'h000, 32'h5, 4'hf);
        check_eq("halt_set", 64'(halt), 64'(1));
        check_eq("halt_code_first", 64'(halt_code), 64'(32'hdead0001));
        rd(32'h000, 32'hdead0001, "halt_rd");

        wr(32'h108, 32'd4, 4'b0011);
        cur_div = 4;
        mon_en = 1'b0;
        tx_push(8'h55, 1'b0);
        tx_push(8'h66, 1'b0);
        bus_idle();
        n = 0;
        do begin @(negedge clk); n++; end while (txd !== 1'b0 && n < 50);
        check_eq("pre_rst_txd_low", 64'(txd), 64'(0));
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_txd", 64'(txd), 64'(1));
        check_eq("async_rst_halt", 64'(halt), 64'(0));
        check_eq("async_rst_halt_code", 64'(halt_code), 64'(0));
        rd_q.delete();
        rd_tag_q.delete();
        tx_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd(32'h104, 32'h3, "status_after_rst");
        rd(32'h108, 32'd868, "div_after_rst");
        repeat (60) @(posedge clk);
        #1;
        check_eq("txd_idle_after_rst", 64'(txd), 64'(1));
        wr(32'h000, 32'h1234, 4'hf);
        check_eq("halt_code_after_rst", 64'(halt_code), 64'(32'h1234));

`ifdef MMIO_UART_CYCLE_COUNTER_EN
        rd(32'h200, cyc_model[31:0], "cnt_lo");
        rd(32'h204, cyc_model[63:32], "cnt_hi");
        repeat (7) @(posedge clk);
        #1;
        rd(32'h200, cyc_model[31:0], "cnt_lo2");
        wr(32'h200, 32'hffffffff, 4'hf);
        rd(32'h200, cyc_model[31:0], "cnt_lo_after_wr");
`else
        rd(32'h200, 32'h0, "cnt_lo_absent");
        rd(32'h204, 32'h0, "cnt_hi_absent");
`endif

        repeat (3) @(posedge clk);
        #1;
        check_eq("rd_q_drained", 64'(rd_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
